imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit instruction words held.
REQ-002 SHALL have parameter ADDR_W, default 5, word-address width (log2 DEPTH).
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port Len  input  6  number of words to load; legal 1..DEPTH.
REQ-007 SHALL have port RxData  input  8  loader byte stream, first byte of each word is MSB.
REQ-008 SHALL have port RxValid  input  1  RxData valid.
REQ-009 SHALL have port RxReady  output  1  controller accepts a byte this cycle.
REQ-010 SHALL have port CpuAddr  input  32  CPU fetch byte address (PC).
REQ-011 SHALL have port CpuInst  output  32  instruction returned to CPU.
REQ-012 SHALL have port CpuStall  output  1  high while CPU must not execute.
REQ-013 SHALL have port Done  output  1  high once a load completed, until next load starts.
REQ-014 SHALL have port Err  output  1  sticky; set by illegal Len at Start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: Start with 1<=Len<=DEPTH SHALL go to LOAD, latch Len, clear word and byte counters, clear Err and Done.
REQ-017 IDLE: Start with Len=0 or Len>DEPTH SHALL set Err=1 and stay IDLE.
REQ-018 LOAD: RxReady SHALL be 1; each cycle with RxValid&RxReady SHALL shift buffer left 8 and insert RxData in bits [7:0], increment byte counter.
REQ-019 On acceptance of the 4th byte of a word, SHALL go to WRITE next cycle (byte counter wraps 3->0).
REQ-020 WRITE: RxReady SHALL be 0; SHALL write buffer to RAM word address = word counter for exactly one cycle.
REQ-021 WRITE: if word counter = latched Len-1 go to DONE, else increment word counter and return to LOAD.
REQ-022 Minimum throughput SHALL be one word per 5 cycles; no bytes accepted in IDLE, WRITE, DONE.
REQ-023 DONE: CpuStall=0, Done=1; Start with legal Len SHALL reload (to LOAD, CpuStall=1, Done=0); illegal Len sets Err, stays DONE.
REQ-024 Start in LOAD or WRITE SHALL be ignored.
REQ-025 CpuStall SHALL be 1 in IDLE, LOAD, WRITE.
REQ-026 Read address SHALL be CpuAddr[ADDR_W+1:2]; other CpuAddr bits ignored; read combinational (zero latency).
REQ-027 CpuInst SHALL equal RAM word when CpuStall=0, else 32'h00000000 (NOP).
REQ-028 Words at addresses >= Len SHALL keep prior contents.

Reset
REQ-029 Reset SHALL force IDLE, RxReady=0, CpuStall=1, Done=0, Err=0, counters and buffer 0, CpuInst=0.
REQ-030 Reset mid-load SHALL abort at the next edge; already-written RAM words SHALL be retained; RAM not cleared.
REQ-031 Reset SHALL override Start and RxValid in the same cycle.

Structure
REQ-032 Package imem_pkg SHALL hold DEPTH, ADDR_W defaults, FSM state encoding, NOP constant 32'h00000000.
REQ-033 Storage SHALL be one sub-module imem_ram: DEPTH x 32, synchronous write, combinational read.
REQ-034 Controller FSM, counters and byte buffer SHALL live in imem_boot_ctrl.

Verification
REQ-035 Reset, Start Len=2, bytes 23 DE 00 0F 40 9E 60 00 back-to-back -> RxReady drops after 4th byte, Done=1 after 10 cycles; CpuAddr=0 -> 23DE000F, CpuAddr=4 -> 409E6000.
REQ-036 Start Len=0, then Len=33 -> Err=1, state IDLE, CpuStall=1, RxReady=0.
REQ-037 RxValid toggling every other cycle, Len=1, bytes 3C 01 80 00 -> word 3C018000 written once, CpuInst=0 until Done=1.
REQ-038 Load Len=32 with word i=i -> CpuAddr 0x7C returns 0000001F; CpuAddr 0x80 wraps to word 0 returns 00000000.
REQ-039 Reset after 6 bytes of Len=2 load -> IDLE, CpuStall=1; word 0 retained (visible after subsequent Len=1 load of word 0 only rewrites word 0).
REQ-040 In DONE, Start Len=1 with new word FFFFFFFF -> CpuStall=1 during reload, then CpuAddr=0 returns FFFFFFFF, word 1 unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the boot-loaded instruction memory.
package imem_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int LEN_W      = 6;
  localparam int BCNT_W     = 2;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A load length is usable when it names at least one word and fits the RAM.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int depth);
    return (len != '0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: synchronous single-port write, combinational read.
// No reset on the array so contents survive a controller reset.
module imem_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  // Single write port, one word per cycle when the controller commits a buffer.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: assembles a big-endian byte stream into 32-bit words,
// writes them into the instruction RAM, and holds the CPU stalled until the
// requested number of words has landed.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  output logic             RxReady,
  input  logic [31:0]      CpuAddr,
  output logic [31:0]      CpuInst,
  output logic             CpuStall,
  output logic             Done,
  output logic             Err
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]         buf_q, buf_d;
  logic                err_q, err_d;

  logic                ram_we;
  logic [31:0]         ram_rdata;
  logic                start_ok;
  logic                last_word;

  assign start_ok  = len_legal(Len, DEPTH);
  // Word counter is narrower than Len; widen it before comparing with Len-1.
  assign last_word = (LEN_W'(word_cnt_q) == (len_q - LEN_W'(1)));

  // State, counters and assembly buffer; reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept Start only when idle/done, shift bytes in LOAD,
  // commit one word per WRITE cycle.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    err_d      = err_q;
    ram_we     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          if (start_ok) begin
            state_d    = ST_LOAD;
            len_d      = Len;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // RxReady is high throughout LOAD, so RxValid alone means a handshake.
        if (RxValid) begin
          buf_d      = {buf_q[23:0], RxData};
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          if (byte_cnt_q == BCNT_W'(3)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_we = 1'b1;
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          state_d    = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (word_cnt_q),
    .wdata (buf_q),
    .raddr (CpuAddr[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  // Only the word-index bits of the PC select an instruction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{CpuAddr[31:ADDR_W+2], CpuAddr[1:0]};

  assign RxReady  = (state_q == ST_LOAD);
  assign CpuStall = (state_q != ST_DONE);
  assign Done     = (state_q == ST_DONE);
  assign Err      = err_q;
  // Feed NOPs while stalled so a speculative fetch never sees half-loaded code.
  assign CpuInst  = CpuStall ? NOP : ram_rdata;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: stimulus queues expected responses
// tagged with the cycle they apply to; a monitor pops and compares them.
module tb_imem_boot_ctrl;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic        Clk = 1'b0;
  logic        Reset, Start, RxValid;
  logic [5:0]  Len;
  logic [7:0]  RxData;
  logic [31:0] CpuAddr;
  wire         RxReady, CpuStall, Done, Err;
  wire  [31:0] CpuInst;

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .CpuAddr(CpuAddr), .CpuInst(CpuInst), .CpuStall(CpuStall),
    .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // kind 0: CpuInst, kind 1: {RxReady,CpuStall,Done,Err}, kind 2: value carried in act
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    logic [31:0] act;
    string       name;
  } exp_t;

  exp_t sq[$];
  int   checks = 0;
  int   errors = 0;

  exp_t        me;
  logic [31:0] mact;
  always @(negedge Clk) begin
    while (sq.size() != 0 && sq[0].cyc <= cyc) begin
      me = sq.pop_front();
      checks++;
      if (me.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at %0d", me.name, me.cyc, cyc);
      end else begin
        case (me.kind)
          0:       mact = CpuInst;
          1:       mact = {28'd0, RxReady, CpuStall, Done, Err};
          default: mact = me.act;
        endcase
        if (mact !== me.exp) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h (cycle %0d)", me.name, mact, me.exp, cyc);
        end
      end
    end
  end

  // Reference model: memory image, which words have ever been written, flags.
  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];
  bit          m_err, m_done;
  logic [31:0] wq[$];

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic push(input int kind, input string n, input logic [31:0] e, input logic [31:0] a);
    exp_t x;
    x.cyc = cyc; x.kind = kind; x.exp = e; x.act = a; x.name = n;
    sq.push_back(x);
  endtask

  task automatic exp_stat(input string n, input bit rdy, input bit stl, input bit dn, input bit er);
    push(1, n, {28'd0, rdy, stl, dn, er}, '0);
  endtask

  task automatic exp_inst(input string n, input logic [31:0] addr, input logic [31:0] e);
    CpuAddr = addr;
    push(0, n, e, '0);
  endtask

  task automatic do_reset();
    // Start and a valid byte in the reset cycle must both be overridden.
    Reset = 1'b1; Start = 1'b1; Len = 6'd1; RxValid = 1'b1; RxData = 8'hAA;
    tick();
    Reset = 1'b0; Start = 1'b0; RxValid = 1'b0;
    m_err = 0; m_done = 0;
    exp_stat("reset_status", 0, 1, 0, 0);
    exp_inst("reset_inst", 32'h0, 32'h0);
    tick();
  endtask

  task automatic do_start(input logic [5:0] len);
    Start = 1'b1; Len = len;
    tick();
    Start = 1'b0;
    if (len >= 1 && int'(len) <= DEPTH) begin
      m_err = 0; m_done = 0;
      exp_stat("start_legal", 1, 1, 0, 0);
    end else begin
      m_err = 1;
      exp_stat("start_illegal", 0, !m_done, m_done, 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    for (int g = 0; g < gap; g++) tick();
    RxValid = 1'b1; RxData = b;
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge Clk);
      acc = RxReady;
      @(posedge Clk); #1;
    end
    RxValid = 1'b0;
    if (!acc) push(2, "rx_timeout", 32'd1, 32'd0);
  endtask

  // Load wq[0..len-1]. gap<0 => random idle cycles per byte.
  // stop_after>=0 stops after that many bytes (for abort tests).
  task automatic load(input int len, input int gap, input bit glitch, input int stop_after);
    int          c0, nb;
    logic [31:0] cur;
    nb = 0;
    do_start(6'(len));
    c0 = cyc;
    for (int w = 0; w < len; w++) begin
      cur = wq[w];
      for (int b = 0; b < 4; b++) begin
        if (nb == stop_after) return;
        send_byte(cur[31-8*b -: 8], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        nb++;
        exp_inst("stall_nop", $urandom, 32'h0);
        if (glitch && w == 0 && b == 0) begin
          Start = 1'b1; Len = 6'd0;
          tick();
          Start = 1'b0;
          exp_stat("start_ignored", 1, 1, 0, 0);
        end
      end
      exp_stat("write_cycle", 0, 1, 0, 0);
      mdl[w] = cur; known[w] = 1;
    end
    tick();
    m_done = 1;
    exp_stat("done", 0, 0, 1, 0);
    if (gap == 0 && !glitch) push(2, "done_latency", 32'(len * 5), 32'(cyc - c0));
  endtask

  task automatic verify_all();
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      if (known[i]) begin
        a = $urandom;
        a[ADDR_W+1:2] = ADDR_W'(i);
        exp_inst("read_word", a, mdl[i]);
        tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Len = '0; RxData = '0; RxValid = 1'b0; CpuAddr = '0;
    m_err = 0; m_done = 0;
    for (int i = 0; i < DEPTH; i++) begin known[i] = 0; mdl[i] = '0; end
    tick();
    do_reset();

    // Two-word back-to-back load
    wq = '{32'h23DE000F, 32'h409E6000};
    load(2, 0, 0, -1);
    exp_inst("w0", 32'h0, 32'h23DE000F); tick();
    exp_inst("w1", 32'h4, 32'h409E6000); tick();

    // Illegal lengths from IDLE
    do_reset();
    do_start(6'd0);
    do_start(6'd33);
    exp_inst("illegal_nop", 32'h0, 32'h0); tick();

    // Half-rate byte stream, single word
    wq = '{32'h3C018000};
    load(1, 1, 0, -1);
    verify_all();

    // Full-depth load and address wrap
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'(i));
    load(DEPTH, -1, 0, -1);
    exp_inst("last_word", 32'h7C, 32'h1F); tick();
    exp_inst("wrap_word", 32'h80, 32'h0); tick();
    verify_all();

    // Illegal Start while DONE: Err set, still serving instructions
    do_start(6'd0);
    do_start(6'd40);
    exp_inst("done_err_read", 32'h8, mdl[2]); tick();

    // Random loads, one with a Start pulse mid-load
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load(n, -1, (r == 1), -1);
      verify_all();
    end

    // Reload from DONE with one word
    wq = '{32'hFFFFFFFF};
    load(1, -1, 0, -1);
    exp_inst("reload_w0", 32'h0, 32'hFFFFFFFF); tick();
    verify_all();

    // Abort after six bytes: word 0 committed, word 1 untouched
    wq = '{32'h12345678, 32'h9ABCDEF0};
    load(2, 0, 0, 6);
    do_reset();
    wq = '{32'hCAFEF00D};
    load(1, -1, 0, -1);
    verify_all();

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
